regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_pkg.sv | 23 ++
 rtl/wb_starve_counter.sv | 30 +++
 rtl/regfile_wb_arbiter.sv | 131 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
package regfile_wb_pkg;

    localparam int unsigned REG_ADDR_W       = 5;
    localparam int unsigned DATA_W           = 32;
    localparam int unsigned STARVE_W         = 3;
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    // Arbiter FSM state; encoding is visible on grant_state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } grant_state_e;

    // One registered writeback beat.
    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_beat_t;

endpackage

// File: rtl/wb_starve_counter.sv
// Saturating stall counter for port 1; at_limit_c flags forced priority.
module wb_starve_counter
    import regfile_wb_pkg::*;
#(
    parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit_c
);

    logic [STARVE_W-1:0] count_q;

    // Clear has priority; increment stops at the limit.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_q <= '0;
        end else if (inc && !at_limit_c) begin
            count_q <= count_q + STARVE_W'(1);
        end
    end

    // Limit-reached flag, used the same cycle by the arbiter.
    always_comb begin
        at_limit_c = (count_q == STARVE_W'(LIMIT));
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter in front of the register-file write port.
// Optional same-cycle bypass of the in-flight write: define REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_valid,
    input  logic                  p0_lock,
    input  logic [REG_ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0]     p0_data,
    output logic                  p0_ready,
    input  logic                  p1_valid,
    input  logic                  p1_lock,
    input  logic [REG_ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0]     p1_data,
    output logic                  p1_ready,
    output logic                  we3,
    output logic [REG_ADDR_W-1:0] wa3,
    output logic [DATA_W-1:0]     wd3,
    input  logic [REG_ADDR_W-1:0] ra1,
    input  logic [REG_ADDR_W-1:0] ra2,
    output logic                  byp_hit1,
    output logic                  byp_hit2,
    output logic [DATA_W-1:0]     byp_data1,
    output logic [DATA_W-1:0]     byp_data2,
    output logic [1:0]            grant_state
);

    grant_state_e state_q, state_d;
    wb_beat_t     stage_q;
    logic         at_limit_c;
    logic         xfer0, xfer1;

    wb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .inc        (p1_valid & ~p1_ready),
        .clr        (~p1_valid | p1_ready),
        .at_limit_c (at_limit_c)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant decode and next state; ready never looks at addr/data.
    always_comb begin
        p0_ready = 1'b0;
        p1_ready = 1'b0;
        state_d  = state_q;
        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    if (p0_valid && p1_valid) begin
                        p1_ready = at_limit_c;
                        p0_ready = ~at_limit_c;
                    end else begin
                        p0_ready = p0_valid;
                        p1_ready = p1_valid;
                    end
                    if (p0_valid && p0_ready && p0_lock) begin
                        state_d = LOCK0;
                    end else if (p1_valid && p1_ready && p1_lock) begin
                        state_d = LOCK1;
                    end
                end
                LOCK0: begin
                    p0_ready = p0_valid;
                    if (p0_valid && !p0_lock) begin
                        state_d = IDLE;
                    end
                end
                LOCK1: begin
                    p1_ready = p1_valid;
                    if (p1_valid && !p1_lock) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign xfer0 = p0_valid & p0_ready;
    assign xfer1 = p1_valid & p1_ready;

    // Output stage: one beat per cycle, zero-register writes suppressed.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else if (xfer0) begin
            stage_q <= '{we: (p0_addr != '0), addr: p0_addr, data: p0_data};
        end else if (xfer1) begin
            stage_q <= '{we: (p1_addr != '0), addr: p1_addr, data: p1_data};
        end else begin
            stage_q <= '0;
        end
    end

    // Reset kills a write already sitting in the stage.
    assign we3         = stage_q.we & ~reset;
    assign wa3         = stage_q.addr;
    assign wd3         = stage_q.data;
    assign grant_state = state_q;

`ifdef REGFILE_WB_BYPASS_EN
    // Forward the in-flight write to matching non-zero read addresses.
    always_comb begin
        byp_hit1  = we3 && (wa3 == ra1) && (ra1 != '0);
        byp_hit2  = we3 && (wa3 == ra2) && (ra2 != '0);
        byp_data1 = byp_hit1 ? wd3 : '0;
        byp_data2 = byp_hit2 ? wd3 : '0;
    end
`else
    assign byp_hit1  = 1'b0;
    assign byp_hit2  = 1'b0;
    assign byp_data1 = '0;
    assign byp_data2 = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table plus random traffic vs. a reference model.
module tb_regfile_wb_arbiter;
    import regfile_wb_pkg::*;

    localparam int unsigned LIMIT = 4;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk, reset;
    logic        p0_valid, p0_lock, p0_ready, p1_valid, p1_lock, p1_ready;
    logic [4:0]  p0_addr, p1_addr, wa3, ra1, ra2;
    logic [31:0] p0_data, p1_data, wd3, byp_data1, byp_data2;
    logic        we3, byp_hit1, byp_hit2;
    logic [1:0]  grant_state;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_data(p0_data), .p0_ready(p0_ready),
        .p1_valid(p1_valid), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_data(p1_data), .p1_ready(p1_ready),
        .we3(we3), .wa3(wa3), .wd3(wd3), .ra1(ra1), .ra2(ra2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data1(byp_data1), .byp_data2(byp_data2),
        .grant_state(grant_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          v0, l0;
        logic [4:0]  a0;
        logic [31:0] d0;
        bit          v1, l1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [4:0]  ra1, ra2;
        bit          e_r0, e_r1;
        int          e_gs;
        bit          e_we;
        logic [4:0]  e_wa;
        bit          e_h1, e_h2;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: lock owner (-1 = nobody), stall count, pending write.
    int          owner = -1;
    int          starve = 0;
    bit          m_we = 0;
    logic [4:0]  m_wa = '0;
    logic [31:0] m_wd = '0;
    bit          m_r0, m_r1, last_t0, last_t1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(bit rst, bit v0, bit l0, logic [4:0] a0, logic [31:0] d0,
                                bit v1, bit l1, logic [4:0] a1, logic [31:0] d1,
                                logic [4:0] r1a, logic [4:0] r2a,
                                bit e_r0, bit e_r1, int e_gs, bit e_we, logic [4:0] e_wa,
                                bit e_h1, bit e_h2);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.l1 = l1; v.a1 = a1; v.d1 = d1; v.ra1 = r1a; v.ra2 = r2a;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_gs = e_gs; v.e_we = e_we; v.e_wa = e_wa;
        v.e_h1 = e_h1; v.e_h2 = e_h2;
        vq.push_back(v);
    endfunction

    // Who may transfer this cycle, from the arbitration rules.
    function automatic void model_ready();
        m_r0 = 0; m_r1 = 0;
        if (reset) return;
        if (owner == 0) m_r0 = p0_valid;
        else if (owner == 1) m_r1 = p1_valid;
        else if (p0_valid && p1_valid) begin
            if (starve == int'(LIMIT)) m_r1 = 1; else m_r0 = 1;
        end else begin
            m_r0 = p0_valid; m_r1 = p1_valid;
        end
    endfunction

    task automatic model_check();
        bit          e_we, e_h1, e_h2;
        logic [31:0] e_d1, e_d2;
        model_ready();
        e_we = m_we && !reset;
        e_h1 = BYP && e_we && (m_wa == ra1) && (ra1 != 0);
        e_h2 = BYP && e_we && (m_wa == ra2) && (ra2 != 0);
        e_d1 = e_h1 ? m_wd : 32'h0;
        e_d2 = e_h2 ? m_wd : 32'h0;
        chk("p0_ready", 32'(p0_ready), 32'(m_r0));
        chk("p1_ready", 32'(p1_ready), 32'(m_r1));
        chk("one_hot_ready", 32'(p0_ready & p1_ready), 32'h0);
        chk("grant_state", 32'(grant_state), 32'(owner + 1));
        chk("we3", 32'(we3), 32'(e_we));
        if (e_we) begin
            chk("wa3", 32'(wa3), 32'(m_wa));
            chk("wd3", wd3, m_wd);
        end
        chk("byp_hit1", 32'(byp_hit1), 32'(e_h1));
        chk("byp_hit2", 32'(byp_hit2), 32'(e_h2));
        chk("byp_data1", byp_data1, e_d1);
        chk("byp_data2", byp_data2, e_d2);
    endtask

    // Advance the model across one rising edge.
    task automatic model_step();
        last_t0 = 0; last_t1 = 0;
        if (reset) begin
            owner = -1; starve = 0; m_we = 0; m_wa = '0; m_wd = '0;
            return;
        end
        last_t0 = p0_valid && m_r0;
        last_t1 = p1_valid && m_r1;
        m_we = 0; m_wa = '0; m_wd = '0;
        if (last_t0) begin
            m_we = (p0_addr != 0); m_wa = p0_addr; m_wd = p0_data;
            owner = p0_lock ? 0 : -1;
        end else if (last_t1) begin
            m_we = (p1_addr != 0); m_wa = p1_addr; m_wd = p1_data;
            owner = p1_lock ? 1 : -1;
        end
        if (p1_valid && !m_r1) starve = (starve < int'(LIMIT)) ? starve + 1 : starve;
        else starve = 0;
    endtask

    task automatic do_cycle(input bit has_row, input int idx, input vec_t v);
        @(negedge clk);
        model_check();
        if (has_row) begin
            chk($sformatf("row%0d_p0_ready", idx), 32'(p0_ready), 32'(v.e_r0));
            chk($sformatf("row%0d_p1_ready", idx), 32'(p1_ready), 32'(v.e_r1));
            chk($sformatf("row%0d_grant_state", idx), 32'(grant_state), 32'(v.e_gs));
            chk($sformatf("row%0d_we3", idx), 32'(we3), 32'(v.e_we));
            if (v.e_we) chk($sformatf("row%0d_wa3", idx), 32'(wa3), 32'(v.e_wa));
            chk($sformatf("row%0d_byp_hit1", idx), 32'(byp_hit1), 32'(v.e_h1));
            chk($sformatf("row%0d_byp_hit2", idx), 32'(byp_hit2), 32'(v.e_h2));
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst;
        p0_valid = v.v0; p0_lock = v.l0; p0_addr = v.a0; p0_data = v.d0;
        p1_valid = v.v1; p1_lock = v.l1; p1_addr = v.a1; p1_data = v.d1;
        ra1 = v.ra1; ra2 = v.ra2;
    endtask

    initial begin
        vec_t        v;
        bit          pend0, pend1;
        bit          q_l0, q_l1;
        logic [4:0]  q_a0, q_a1;
        logic [31:0] q_d0, q_d1;

        reset = 1; p0_valid = 0; p0_lock = 0; p0_addr = '0; p0_data = '0;
        p1_valid = 0; p1_lock = 0; p1_addr = '0; p1_data = '0; ra1 = '0; ra2 = '0;
        repeat (2) @(posedge clk);
        #1;

        //  rst v0 l0 a0  d0            v1 l1 a1  d1        ra1 ra2 r0 r1 gs we wa  h1   h2
        add(1, 1, 0, 5'd7, 32'h7,          0, 0, 5'd0, 32'h0,    0, 0, 0, 0, 0, 0, 0,  0,  0);
        add(0, 0, 0, 5'd0, 32'h0,          0, 0, 5'd0, 32'h0,    0, 0, 0, 0, 0, 0, 0,  0,  0);
        add(0, 1, 0, 5'd8, 32'hA5A5_0001,  0, 0, 5'd0, 32'h0,    0, 0, 1, 0, 0, 0, 0,  0,  0);
        add(0, 0, 0, 5'd0, 32'h0,          0, 0, 5'd0, 32'h0,    0, 0, 0, 0, 0, 1, 8,  0,  0);
        add(0, 0, 0, 5'd0, 32'h0,          0, 0, 5'd0, 32'h0,    0, 0, 0, 0, 0, 0, 0,  0,  0);
        for (int k = 0; k < 10; k++) begin
            bit p1_turn;
            bit we_now;
            logic [4:0] wa_now;
            p1_turn = (k == 4) || (k == 9);
            we_now  = (k != 0);
            wa_now  = (k == 5) ? 5'd2 : 5'd1;
            add(0, 1, 0, 5'd1, 32'h101, 1, 0, 5'd2, 32'h202, 0, 0,
                !p1_turn, p1_turn, 0, we_now, wa_now, 0, 0);
        end
        add(0, 0, 0, 5'd0, 32'h0,          0, 0, 5'd0,  32'h0,   0, 0, 0, 0, 0, 1, 2,  0,  0);
        add(0, 0, 0, 5'd0, 32'h0,          0, 0, 5'd0,  32'h0,   0, 0, 0, 0, 0, 0, 0,  0,  0);
        add(0, 0, 0, 5'd0, 32'h0,          1, 1, 5'd10, 32'hA0,  0, 0, 0, 1, 0, 0, 0,  0,  0);
        add(0, 1, 0, 5'd3, 32'h33,         0, 0, 5'd0,  32'h0,   0, 0, 0, 0, 2, 1, 10, 0,  0);
        add(0, 1, 0, 5'd3, 32'h33,         0, 0, 5'd0,  32'h0,   0, 0, 0, 0, 2, 0, 0,  0,  0);
        add(0, 1, 0, 5'd3, 32'h33,         1, 0, 5'd11, 32'hB0,  0, 0, 0, 1, 2, 0, 0,  0,  0);
        add(0, 1, 0, 5'd3, 32'h33,         0, 0, 5'd0,  32'h0,   0, 0, 1, 0, 0, 1, 11, 0,  0);
        add(0, 0, 0, 5'd0, 32'h0,          0, 0, 5'd0,  32'h0,   0, 0, 0, 0, 0, 1, 3,  0,  0);
        add(0, 1, 0, 5'd0, 32'hFFFF_FFFF,  0, 0, 5'd0,  32'h0,   0, 0, 1, 0, 0, 0, 0,  0,  0);
        add(0, 0, 0, 5'd0, 32'h0,          0, 0, 5'd0,  32'h0,   0, 0, 0, 0, 0, 0, 0,  0,  0);
        add(0, 1, 1, 5'd5, 32'h55,         0, 0, 5'd0,  32'h0,   0, 0, 1, 0, 0, 0, 0,  0,  0);
        add(1, 1, 0, 5'd6, 32'h66,         0, 0, 5'd0,  32'h0,   0, 0, 0, 0, 1, 0, 0,  0,  0);
        add(0, 1, 0, 5'd6, 32'h66,         0, 0, 5'd0,  32'h0,   0, 0, 1, 0, 0, 0, 0,  0,  0);
        add(0, 0, 0, 5'd0, 32'h0,          0, 0, 5'd0,  32'h0,   0, 0, 0, 0, 0, 1, 6,  0,  0);
        add(0, 0, 0, 5'd0, 32'h0,          1, 0, 5'd9,  32'h1234, 9, 8, 0, 1, 0, 0, 0,  0,  0);
        add(0, 0, 0, 5'd0, 32'h0,          0, 0, 5'd0,  32'h0,   9, 8, 0, 0, 0, 1, 9, BYP, 0);
        add(0, 0, 0, 5'd0, 32'h0,          0, 0, 5'd0,  32'h0,   9, 8, 0, 0, 0, 0, 0,  0,  0);

        foreach (vq[i]) begin
            drive(vq[i]);
            do_cycle(1'b1, i, vq[i]);
        end

        // Random traffic; each requester holds its beat until accepted.
        pend0 = 0; pend1 = 0;
        q_l0 = 0; q_l1 = 0; q_a0 = '0; q_a1 = '0; q_d0 = '0; q_d1 = '0;
        v = vq[0];
        for (int c = 0; c < 1500; c++) begin
            if (last_t0) pend0 = 0;
            if (last_t1) pend1 = 0;
            if (!pend0 && ($urandom_range(0, 9) < 7)) begin
                pend0 = 1; q_l0 = ($urandom_range(0, 3) == 0);
                q_a0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                q_d0 = $urandom;
            end
            if (!pend1 && ($urandom_range(0, 9) < 7)) begin
                pend1 = 1; q_l1 = ($urandom_range(0, 3) == 0);
                q_a1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                q_d1 = $urandom;
            end
            v.rst = ($urandom_range(0, 99) == 0);
            v.v0 = pend0; v.l0 = q_l0; v.a0 = q_a0; v.d0 = q_d0;
            v.v1 = pend1; v.l1 = q_l1; v.a1 = q_a1; v.d1 = q_d1;
            v.ra1 = $urandom_range(0, 1) ? m_wa : 5'($urandom);
            v.ra2 = $urandom_range(0, 1) ? m_wa : 5'($urandom);
            drive(v);
            do_cycle(1'b0, c, v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
